// File: rtl/tc_pkg.sv
// Shared psum types and arithmetic helpers for the systolic-array drain path.
package tc_pkg;
  localparam int PSUM_W = 32;

  typedef logic signed [PSUM_W-1:0] psum_t;

  // Signed add that clamps to the psum range instead of wrapping.
  function automatic psum_t sat_add(psum_t a, psum_t b);
    logic signed [PSUM_W:0] s;
    s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    if (s[PSUM_W] != s[PSUM_W-1])
      sat_add = s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    else
      sat_add = s[PSUM_W-1:0];
  endfunction
endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to separate full from empty.
module psum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr, r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_empty, w_do_push, w_do_pop;

  assign w_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_valid   = !w_empty;
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/psum_drain.sv
// Deskews column psums, accumulates rows across tiles and queues finished rows.
// Define PSUM_DRAIN_SAT_EN for saturating accumulation (default wraps).
module psum_drain
  import tc_pkg::*;
#(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*PSUM_W-1:0]    col_psum_in,
  input  logic [N-1:0]           col_valid_in,
  input  logic                   tile_first,
  input  logic                   tile_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*PSUM_W-1:0]    out_data,
  output logic [$clog2(M)-1:0]   out_row,
  output logic                   err_skew,
  output logic                   err_ovf
);
  localparam int RW = $clog2(M);
  localparam int FW = N*PSUM_W + RW;

  psum_t [N-1:0] w_dly_psum;
  logic  [N-1:0] w_dly_vld;
  logic          w_first, w_last;

  // Column c lags column 0 by c cycles, so it needs N-1-c stages to line up.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int D = N-1-c;
    if (D == 0) begin : g_pass
      assign w_dly_psum[c] = col_psum_in[c*PSUM_W +: PSUM_W];
      assign w_dly_vld[c]  = col_valid_in[c];
    end else begin : g_dly
      psum_t [D-1:0] r_p;
      logic  [D-1:0] r_v;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_p <= '0;
          r_v <= '0;
        end else begin
          r_p[0] <= col_psum_in[c*PSUM_W +: PSUM_W];
          r_v[0] <= col_valid_in[c];
          for (int k = 1; k < D; k++) begin
            r_p[k] <= r_p[k-1];
            r_v[k] <= r_v[k-1];
          end
        end
      end
      assign w_dly_psum[c] = r_p[D-1];
      assign w_dly_vld[c]  = r_v[D-1];
    end
  end

  if (N == 1) begin : g_flg_pass
    assign w_first = tile_first;
    assign w_last  = tile_last;
  end else begin : g_flg
    logic [N-2:0] r_f, r_l;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_f <= '0;
        r_l <= '0;
      end else begin
        r_f[0] <= tile_first;
        r_l[0] <= tile_last;
        for (int k = 1; k < N-1; k++) begin
          r_f[k] <= r_f[k-1];
          r_l[k] <= r_l[k-1];
        end
      end
    end
    assign w_first = r_f[N-2];
    assign w_last  = r_l[N-2];
  end

  function automatic psum_t f_add(psum_t a, psum_t b);
`ifdef PSUM_DRAIN_SAT_EN
    return sat_add(a, b);
`else
    return a + b;
`endif
  endfunction

  logic [RW-1:0] r_row;
  psum_t [N-1:0] r_acc [M];
  psum_t [N-1:0] w_sum;
  logic          w_all, w_any, w_push, w_full, w_ovf;
  logic          r_err_skew, r_err_ovf;
  logic [FW-1:0] w_fifo_data;

  assign w_all  = &w_dly_vld;
  assign w_any  = |w_dly_vld;
  assign w_push = !rst && w_all && w_last;
  assign w_ovf  = w_push && w_full && !(out_valid && out_ready);

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < N; c++)
      w_sum[c] = w_first ? w_dly_psum[c] : f_add(r_acc[r_row][c], w_dly_psum[c]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_err_skew <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_all)          r_row      <= (r_row == RW'(M-1)) ? '0 : r_row + RW'(1);
      if (w_any && !w_all) r_err_skew <= 1'b1;
      if (w_ovf)          r_err_ovf  <= 1'b1;
    end
  end

  // Accumulators are left unreset: a first row always overwrites its slot.
  always_ff @(posedge clk) begin
    if (!rst && w_all) r_acc[r_row] <= w_sum;
  end

  assign err_skew = r_err_skew;
  assign err_ovf  = r_err_ovf;

  psum_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_row, w_sum}),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_data  (w_fifo_data)
  );

  assign {out_row, out_data} = w_fifo_data;
endmodule

// File: tb/tb_psum_drain.sv
// Directed + random bench for psum_drain against a row-level queue model.
module tb_psum_drain;
  localparam int N = 4, M = 4, DEPTH = 8, RW = 2;
  localparam longint PMAX = 64'sh7FFFFFFF;
  localparam longint NMIN = -64'sh80000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*32-1:0]   col_psum_in;
  logic [N-1:0]      col_valid_in;
  logic              tile_first, tile_last, out_ready;
  logic              out_valid, err_skew, err_ovf;
  logic [N*32-1:0]   out_data;
  logic [RW-1:0]     out_row;

  always #5 clk = ~clk;

  psum_drain #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .col_psum_in(col_psum_in), .col_valid_in(col_valid_in),
    .tile_first(tile_first), .tile_last(tile_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .err_skew(err_skew), .err_ovf(err_ovf)
  );

  typedef struct packed {
    int                   start;
    logic [N-1:0][31:0]   d;
    logic                 first;
    logic                 last;
    int                   late;
  } row_t;

  typedef struct packed {
    logic [RW-1:0]        row;
    logic [N-1:0][31:0]   d;
  } exp_t;

  row_t               rows[$];
  exp_t               exp_q[$];
  logic [N-1:0][31:0] macc [M];
  int                 mr, gen_r, cyc, rdy_mode;
  bit                 m_skew, m_ovf, after_rst, chk_en;
  bit                 gen_def [M];
  logic [31:0]        last_pop0;
  int                 n_assert, n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] madd(logic [31:0] a, logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_DRAIN_SAT_EN
    if (s > PMAX) return 32'h7FFFFFFF;
    if (s < NMIN) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic add_row(input int s, input logic [N-1:0][31:0] d, input bit f, input bit l,
                         input int late);
    row_t rw;
    rw.start = s; rw.d = d; rw.first = f; rw.last = l; rw.late = late;
    rows.push_back(rw);
    if (late < 0) begin
      gen_def[gen_r] = 1'b1;
      gen_r = (gen_r + 1) % M;
    end
  endtask

  // One aligned row: accumulate into slot mr and queue it if it closes the tile.
  task automatic aligned(input row_t rw);
    logic [N-1:0][31:0] s;
    for (int c = 0; c < N; c++) s[c] = rw.first ? rw.d[c] : madd(macc[mr][c], rw.d[c]);
    macc[mr] = s;
    if (rw.last) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({RW'(mr), s});
      else m_ovf = 1'b1;
    end
    mr = (mr + 1) % M;
  endtask

  task automatic step(input bit rst_now);
    int x;
    bit pop;
    @(posedge clk); #1;
    x = cyc;
    rst = rst_now;
    col_valid_in = '0; col_psum_in = '0; tile_first = 1'b0; tile_last = 1'b0;
    foreach (rows[k]) begin
      for (int c = 0; c < N; c++) begin
        if (rows[k].start + c + ((c == rows[k].late) ? 1 : 0) == x) begin
          col_valid_in[c] = 1'b1;
          col_psum_in[c*32 +: 32] = rows[k].d[c];
          if (c == 0) begin tile_first = rows[k].first; tile_last = rows[k].last; end
        end
      end
    end
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    if (chk_en) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_row", out_row, exp_q[0].row);
      end else if (after_rst) begin
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
      end
      chk("err_skew", err_skew, m_skew);
      chk("err_ovf", err_ovf, m_ovf);
    end
    pop = (exp_q.size() != 0) && out_ready;
    if (pop) begin
      last_pop0 = exp_q[0].d[0];
      void'(exp_q.pop_front());
    end
    if (rst_now) begin
      exp_q.delete(); rows.delete();
      mr = 0; gen_r = 0; m_skew = 1'b0; m_ovf = 1'b0; after_rst = 1'b1;
      foreach (gen_def[i]) gen_def[i] = 1'b0;
    end else begin
      after_rst = 1'b0;
      foreach (rows[k]) begin
        if (rows[k].start + N - 1 == x) begin
          if (rows[k].late >= 0) m_skew = 1'b1;
          else aligned(rows[k]);
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    int s;
    logic [N-1:0][31:0] d;
    rst = 1'b1; col_psum_in = '0; col_valid_in = '0;
    tile_first = 1'b0; tile_last = 1'b0; out_ready = 1'b0;
    cyc = 0; n_assert = 0; n_fail = 0; rdy_mode = 1; chk_en = 1'b0;
    last_pop0 = '0; mr = 0; gen_r = 0;
    do_reset();
    chk_en = 1'b1;
    repeat (2) step(1'b0);

    // single row, first=last=1, latency T+N
    s = cyc + 1;
    add_row(s, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b1, 1'b1, -1);
    repeat (10) step(1'b0);
    chk("single_row_col0", last_pop0, 32'd10);

    // two tiles of 5 then 7 -> 12 per column, rows 0..3
    do_reset();
    s = cyc + 1;
    for (int i = 0; i < M; i++) add_row(s + i, {N{32'd5}}, 1'b1, 1'b0, -1);
    for (int i = 0; i < M; i++) add_row(s + M + i, {N{32'd7}}, 1'b0, 1'b1, -1);
    repeat (2*M + 10) step(1'b0);
    chk("two_tile_sum", last_pop0, 32'd12);

    // column 2 one cycle late -> sticky skew error, no push
    do_reset();
    s = cyc + 1;
    add_row(s, {N{32'd9}}, 1'b1, 1'b1, 2);
    repeat (12) step(1'b0);
    chk("skew_sticky", err_skew, 1'b1);
    chk("skew_no_push", out_valid, 1'b0);

    // overflow: 9 rows into an 8-deep FIFO with the consumer stalled
    do_reset();
    rdy_mode = 0;
    s = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < N; c++) d[c] = $urandom;
      add_row(s + i, d, 1'b1, 1'b1, -1);
    end
    repeat (20) step(1'b0);
    chk("ovf_sticky", err_ovf, 1'b1);
    rdy_mode = 1;
    repeat (12) step(1'b0);

    // accumulation crossing the positive limit
    do_reset();
    s = cyc + 1;
    for (int i = 0; i < M; i++) add_row(s + i, {N{32'h7FFFFFF0}}, 1'b1, 1'b0, -1);
    for (int i = 0; i < M; i++) add_row(s + M + i, {N{32'h00000020}}, 1'b0, 1'b1, -1);
    repeat (2*M + 10) step(1'b0);
`ifdef PSUM_DRAIN_SAT_EN
    chk("sat_limit", last_pop0, 32'h7FFFFFFF);
`else
    chk("wrap_limit", last_pop0, 32'h80000010);
`endif

    // reset two cycles into a row: nothing emerges, row counter restarts
    do_reset();
    s = cyc + 1;
    add_row(s, {N{32'd1}}, 1'b1, 1'b1, -1);
    while (cyc < s + 2) step(1'b0);
    step(1'b1);
    repeat (8) step(1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_skew", err_skew, 1'b0);
    add_row(cyc + 1, {N{32'd3}}, 1'b1, 1'b1, -1);
    repeat (8) step(1'b0);

    // random rows, random tile flags and random back-pressure
    do_reset();
    rdy_mode = 2;
    s = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      bit f;
      for (int c = 0; c < N; c++) d[c] = $urandom;
      f = !gen_def[gen_r] || ($urandom_range(0, 3) == 0);
      add_row(s, d, f, 1'($urandom_range(0, 1)), -1);
      s += $urandom_range(1, 2);
    end
    repeat (s - cyc + 10) step(1'b0);
    rdy_mode = 1;
    repeat (DEPTH + 4) step(1'b0);
    chk("drained", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter N, default 4: number of array columns drained.
REQ-002 Parameter M, default 4: rows per tile; accumulator bank depth.
REQ-003 Parameter DEPTH, default 8: output FIFO entries, power of two.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 col_psum_in  in  N*32  signed psum from bottom PE of each column; column c in bits [32c+31:32c].
REQ-007 col_valid_in  in  N  per-column valid; column c arrives c cycles after column 0 for the same row.
REQ-008 tile_first  in  1  sampled with col_valid_in[0]: row starts a new accumulation.
REQ-009 tile_last  in  1  sampled with col_valid_in[0]: row completes accumulation and is emitted.
REQ-010 out_valid  out  1  FIFO head valid.
REQ-011 out_ready  in  1  consumer accepts head when out_valid and out_ready are both high.
REQ-012 out_data  out  N*32  aligned accumulated row, column 0 in low bits.
REQ-013 out_row  out  $clog2(M)  row index of out_data within tile.
REQ-014 err_skew  out  1  sticky: partial-valid aligned row detected.
REQ-015 err_ovf  out  1  sticky: push attempted while FIFO full.

Function
REQ-016 Deskew: column c psum/valid delayed by N-1-c register stages; tile flags delayed N-1 stages with column 0.
REQ-017 Aligned row valid = AND of all delayed valids; if some but not all delayed valids high, set err_skew and discard that cycle's data.
REQ-018 Row counter r increments per aligned row, wraps M-1 -> 0; reset value 0.
REQ-019 Aligned row with first=1: acc[r] <= row; with first=0: acc[r] <= acc[r] + row, per column, 32-bit signed.
REQ-020 Aligned row with last=1: push (first ? row : acc[r] + row) with index r into FIFO; acc[r] still updated.
REQ-021 first=1 and last=1 together: row pushed unmodified.
REQ-022 Latency: column 0 data at cycle T, with all columns aligned -> out_valid high at T+N when FIFO was empty.
REQ-023 Array cannot stall: push into full FIFO drops the row, sets err_ovf; simultaneous pop and push when full succeeds without error.
REQ-024 Pop only when out_valid and out_ready; out_data/out_row stable while out_valid and not out_ready.
REQ-025 FIFO pointers wrap modulo DEPTH; full/empty distinguished by extra pointer bit.

Reset
REQ-026 rst clears delay lines, r, FIFO pointers, err_skew, err_ovf; out_valid=0, out_data=0, out_row=0 next cycle.
REQ-027 Accumulator contents need not be cleared; first=1 defines them.
REQ-028 rst mid-tile discards all in-flight rows; no push occurs in the reset cycle.

Configuration
REQ-029 Macro PSUM_DRAIN_SAT_EN defined: additions saturate to 32'h7FFFFFFF / 32'h80000000.
REQ-030 Macro absent: additions wrap two's-complement modulo 2^32.

Structure
REQ-031 Shared package tc_pkg holds PSUM_W=32, psum_t typedef, saturating-add function.
REQ-032 One sub-module: psum_fifo (synchronous FIFO, DEPTH x (N*32+$clog2(M))).

Verification (N=4, M=4, DEPTH=8)
REQ-033 Single row psum {40,30,20,10} skewed correctly, first=last=1 -> out_data {40,30,20,10}, out_row 0, out_valid at T+4.
REQ-034 Two tiles, rows psum 5 then 7 per column, first on tile 1, last on tile 2 -> each column 12, out_row 0..3.
REQ-035 Column 2 valid one cycle late -> err_skew=1, no push, err_skew held until rst.
REQ-036 out_ready=0, 9 last-rows pushed -> 8 held, err_ovf=1, order preserved on drain.
REQ-037 acc 32'h7FFFFFF0 + 32'h20: SAT_EN -> 32'h7FFFFFFF; else 32'h80000010.
REQ-038 rst asserted at T+2 of a row -> no out_valid afterwards, r=0, flags cleared.
